mux3_scanner: RTL and testbench
===============================

# mux3_scanner

Sequencer that sits directly upstream of the 3:1 select mux. It drives the mux's 2-bit select `s` through channels 0, 1, 2 in turn and holds each channel for a programmable dwell time. On the last dwell cycle of each channel it samples the mux output `r`. After channel 2 it presents the three captured bits as one vector with a single-cycle valid pulse. It supports one-shot frames triggered by `start` and continuous back-to-back frames.

## Interface
- `DWELL`, default 4: cycles `s` is held per channel; legal range 1..16; dwell counter width is `$clog2(DWELL)`, minimum 1 bit.
- `clk`  in  1  system clock; all state updates on the rising edge.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `start`  in  1  begin a frame; sampled only in IDLE.
- `cont`  in  1  continuous mode; sampled at each end of frame.
- `r`  in  1  mux output being scanned.
- `s`  out  2  mux select; only 00, 01 or 10 is ever driven (11 never driven).
- `data`  out  3  last completed frame: bit0 = channel 0 (a), bit1 = channel 1 (b), bit2 = channel 2 (c).
- `valid`  out  1  one-cycle pulse; `data` has just been updated.
- `busy`  out  1  high while in SCAN.

## Operation
- All outputs are registered.
- Reset values: `s`=00, `data`=000, `valid`=0, `busy`=0, state IDLE, channel index `ch`=0, dwell counter `cnt`=0, shadow bits cleared.
- States:
  - IDLE: `s`=00, `busy`=0. On `start`=1, go to SCAN with `ch`=0 and `cnt`=0.
  - SCAN: `s`=`ch`, `busy`=1. Each cycle `cnt` increments.
  - When `cnt`==DWELL-1:
    - Sample `r` into shadow[`ch`].
    - Set `cnt` to 0.
    - If `ch`<2, increment `ch`.
    - If `ch`==2 (end of frame): `data` <= {`r`, shadow[1], shadow[0]} and `valid` <= 1 for one cycle. Then, if `cont`=1, stay in SCAN with `ch`=0. Otherwise go to IDLE.
- `r` is ignored on every cycle except the last dwell cycle of each channel.
- `start` is ignored in SCAN. It is level-sampled in IDLE, so if `start` is held high, a new frame begins the cycle after the return to IDLE.
- Deasserting `cont` mid-frame does not abort the frame. The frame completes and the block then returns to IDLE.
- `data` holds its value between `valid` pulses and is never partially updated.
- Asserting `rst_n` low mid-frame:
  - Returns all outputs to their reset values immediately.
  - The partial frame is discarded and produces no `valid`.

## Timing
- Edge E0 is the edge at which `start`=1 is sampled in IDLE.
  - After E0: `busy`=1, `s`=00.
  - Channel k is driven for cycles k·DWELL+1 .. (k+1)·DWELL.
  - `r` for channel k is sampled at edge E(k+1)·DWELL.
- Start-to-valid latency is 3·DWELL cycles. `valid` and the new `data` appear together after edge E3·DWELL and last one cycle.
- One-shot mode: `busy` falls and `s` returns to 00 in the same cycle `valid` is high.
- Continuous mode: `s` returns to 00 in the `valid` cycle, and `valid` pulses repeat every 3·DWELL cycles with no gap cycles.
- DWELL=1: `s` changes every cycle. `r` is sampled in the same cycle `s` selects that channel, relying on the mux being combinational.

## Test plan
- Reset: hold `rst_n`=0 with random `start`/`r` -> `s`=00, `data`=000, `valid`=0, `busy`=0. Outputs are immediately zero when `rst_n` falls asynchronously mid-cycle.
- One-shot, DWELL=4, channel inputs a=1, b=0, c=1:
  - Pulse `start` -> `s` sequence 00×4, 01×4, 10×4.
  - `valid`=1 exactly 12 cycles after E0 with `data`=101.
  - `busy`=0 in that cycle.
- Sample point: DWELL=4 with a=1, b=1, c=0 held only on each channel's last dwell cycle and inverted on the other three cycles -> `data`=011.
- Continuous: `cont`=1, DWELL=2, c toggling per frame:
  - `valid` every 6 cycles; `data` alternates 0x1/1x1 as c toggles.
  - Drop `cont` mid-frame -> that frame completes with `valid`, then `busy`=0.
- `start` held high during SCAN -> no restart or extra `valid` within the frame. A new frame starts one cycle after the return to IDLE.
- Reset mid-frame: assert `rst_n`=0 at cycle 7 of a DWELL=4 frame -> no `valid`, `data` stays 000. A fresh `start` after reset yields a correct frame 12 cycles later.

Source files
------------

// File: rtl/mux3_scanner.sv
// Drives the select of a 3:1 mux through channels 0..2, holding each for DWELL cycles,
// and samples the mux output on the last dwell cycle to build a 3-bit frame.
module mux3_scanner #(
    parameter int DWELL = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic       cont,
    input  logic       r,
    output logic [1:0] s,
    output logic [2:0] data,
    output logic       valid,
    output logic       busy
);

    localparam int CW = (DWELL > 1) ? $clog2(DWELL) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(DWELL - 1);

    typedef enum logic {
        IDLE,
        SCAN
    } state_t;

    state_t          state_reg, state_next;
    logic [1:0]      ch_reg, ch_next;
    logic [CW-1:0]   cnt_reg, cnt_next;
    logic [1:0]      shadow_reg, shadow_next;
    logic [1:0]      s_next;
    logic [2:0]      data_next;
    logic            valid_next;
    logic            busy_next;
    logic            capture;

    // r is only meaningful on the last dwell cycle of a channel
    assign capture = (state_reg == SCAN) && (cnt_reg == CNT_LAST);

    // Channel 2 never needs a shadow bit: it goes straight into data
    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_shadow
            assign shadow_next[gi] = (capture && (ch_reg == 2'(gi))) ? r : shadow_reg[gi];
        end
    endgenerate

    always_comb begin
        state_next = state_reg;
        ch_next    = ch_reg;
        cnt_next   = cnt_reg;
        s_next     = 2'b00;
        data_next  = data;
        valid_next = 1'b0;
        busy_next  = 1'b0;

        if (state_reg == IDLE) begin
            if (start) begin
                state_next = SCAN;
                ch_next    = 2'd0;
                cnt_next   = '0;
                busy_next  = 1'b1;
            end
        end else begin
            busy_next = 1'b1;
            s_next    = ch_reg;
            cnt_next  = cnt_reg + CW'(1);
            if (capture) begin
                cnt_next = '0;
                if (ch_reg != 2'd2) begin
                    ch_next = ch_reg + 2'd1;
                    s_next  = ch_reg + 2'd1;
                end else begin
                    data_next  = {r, shadow_reg[1], shadow_reg[0]};
                    valid_next = 1'b1;
                    ch_next    = 2'd0;
                    s_next     = 2'b00;
                    if (!cont) begin
                        state_next = IDLE;
                        busy_next  = 1'b0;
                    end
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg  <= IDLE;
            ch_reg     <= 2'd0;
            cnt_reg    <= '0;
            shadow_reg <= 2'b00;
            s          <= 2'b00;
            data       <= 3'b000;
            valid      <= 1'b0;
            busy       <= 1'b0;
        end else begin
            state_reg  <= state_next;
            ch_reg     <= ch_next;
            cnt_reg    <= cnt_next;
            shadow_reg <= shadow_next;
            s          <= s_next;
            data       <= data_next;
            valid      <= valid_next;
            busy       <= busy_next;
        end
    end

endmodule

// File: tb/tb_mux3_scanner.sv
// Directed bench for mux3_scanner: one DWELL=4 instance for one-shot/reset cases,
// one DWELL=2 instance for continuous mode.
module tb_mux3_scanner;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic       start4 = 1'b0, cont4 = 1'b0, r4 = 1'b0;
    logic [1:0] s4;
    logic [2:0] data4;
    logic       valid4, busy4;

    logic       start2 = 1'b0, cont2 = 1'b0, r2 = 1'b0;
    logic [1:0] s2;
    logic [2:0] data2;
    logic       valid2, busy2;

    mux3_scanner #(.DWELL(4)) dut4 (
        .clk(clk), .rst_n(rst_n), .start(start4), .cont(cont4), .r(r4),
        .s(s4), .data(data4), .valid(valid4), .busy(busy4)
    );

    mux3_scanner #(.DWELL(2)) dut2 (
        .clk(clk), .rst_n(rst_n), .start(start2), .cont(cont2), .r(r2),
        .s(s2), .data(data2), .valid(valid2), .busy(busy2)
    );

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [2:0] vals;   // bit k = value of channel k on its sample cycle
        bit         inv;    // drive the inverse on non-sample cycles
        logic [2:0] exp;
    } vec_t;

    vec_t vecs[6];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One DWELL=4 one-shot frame; entered and left in IDLE, #1 after an edge.
    task automatic frame4(input int idx, input logic [2:0] vals, input bit inv, input logic [2:0] exp);
        int  k;
        bit  last;
        start4 = 1'b1;
        tick();
        start4 = 1'b0;
        for (int n = 1; n <= 12; n++) begin
            k    = (n - 1) / 4;
            last = (n % 4) == 0;
            r4   = (last || !inv) ? vals[k] : ~vals[k];
            check("f4_s", 32'(s4), 32'(k));
            check("f4_busy", 32'(busy4), 32'd1);
            check("f4_valid_early", 32'(valid4), 32'd0);
            tick();
        end
        check("f4_valid", 32'(valid4), 32'd1);
        check("f4_data", 32'(data4), 32'(exp));
        check("f4_busy_end", 32'(busy4), 32'd0);
        check("f4_s_end", 32'(s4), 32'd0);
        $display("frame4 vec=%0d inv=%0b data=%b", idx, inv, data4);
        tick();
        check("f4_valid_pulse", 32'(valid4), 32'd0);
        check("f4_data_hold", 32'(data4), 32'(exp));
    endtask

    initial begin
        vecs[0] = '{vals: 3'b101, inv: 1'b0, exp: 3'b101};
        vecs[1] = '{vals: 3'b011, inv: 1'b1, exp: 3'b011};
        vecs[2] = '{vals: 3'b110, inv: 1'b0, exp: 3'b110};
        vecs[3] = '{vals: 3'b000, inv: 1'b1, exp: 3'b000};
        vecs[4] = '{vals: 3'b111, inv: 1'b0, exp: 3'b111};
        vecs[5] = '{vals: 3'b010, inv: 1'b1, exp: 3'b010};

        // Reset held with random inputs
        for (int i = 0; i < 5; i++) begin
            start4 = 1'($urandom_range(0, 1));
            r4     = 1'($urandom_range(0, 1));
            start2 = 1'($urandom_range(0, 1));
            r2     = 1'($urandom_range(0, 1));
            tick();
            check("rst_s", 32'(s4), 32'd0);
            check("rst_data", 32'(data4), 32'd0);
            check("rst_valid", 32'(valid4), 32'd0);
            check("rst_busy", 32'(busy4), 32'd0);
            check("rst_busy2", 32'(busy2), 32'd0);
        end
        start4 = 1'b0;
        start2 = 1'b0;
        rst_n  = 1'b1;
        tick();
        $display("reset released");

        for (int v = 0; v < 6; v++) begin
            frame4(v, vecs[v].vals, vecs[v].inv, vecs[v].exp);
        end

        // Asynchronous reset at cycle 7 of a frame
        start4 = 1'b1;
        r4     = 1'b1;
        tick();
        start4 = 1'b0;
        for (int n = 1; n < 7; n++) tick();
        check("mid_busy_before", 32'(busy4), 32'd1);
        #2 rst_n = 1'b0;
        #1;
        check("async_s", 32'(s4), 32'd0);
        check("async_busy", 32'(busy4), 32'd0);
        check("async_valid", 32'(valid4), 32'd0);
        check("async_data", 32'(data4), 32'd0);
        tick();
        tick();
        rst_n = 1'b1;
        for (int n = 0; n < 14; n++) begin
            tick();
            check("post_rst_valid", 32'(valid4), 32'd0);
            check("post_rst_busy", 32'(busy4), 32'd0);
            check("post_rst_data", 32'(data4), 32'd0);
        end
        $display("mid-frame reset discarded frame");
        frame4(99, 3'b101, 1'b0, 3'b101);

        // start held high through a frame
        start4 = 1'b1;
        r4     = 1'b1;
        tick();
        for (int n = 1; n <= 12; n++) begin
            check("hold_valid", 32'(valid4), 32'd0);
            check("hold_busy", 32'(busy4), 32'd1);
            tick();
        end
        check("hold_valid_end", 32'(valid4), 32'd1);
        check("hold_data", 32'(data4), 32'd7);
        check("hold_idle", 32'(busy4), 32'd0);
        tick();
        start4 = 1'b0;
        r4     = 1'b0;
        check("hold_restart_busy", 32'(busy4), 32'd1);
        check("hold_restart_s", 32'(s4), 32'd0);
        check("hold_restart_valid", 32'(valid4), 32'd0);
        for (int n = 2; n <= 12; n++) tick();
        check("hold_f2_novalid", 32'(valid4), 32'd0);
        tick();
        check("hold_f2_valid", 32'(valid4), 32'd1);
        check("hold_f2_data", 32'(data4), 32'd0);
        $display("held-start frames data=%b", data4);
        tick();

        // Continuous mode, DWELL=2: a=1, b=1, c toggles per frame; cont dropped in frame 2
        cont2  = 1'b1;
        start2 = 1'b1;
        tick();
        start2 = 1'b0;
        for (int n = 1; n <= 20; n++) begin
            int f, p, k;
            logic [2:0] fv;
            f  = (n - 1) / 6;
            p  = (n - 1) % 6;
            k  = p / 2;
            fv = (f % 2 == 1) ? 3'b111 : 3'b011;
            if (n == 14) cont2 = 1'b0;
            if (n <= 18) r2 = fv[k];
            check("cont_s", 32'(s2), (n <= 18) ? 32'(k) : 32'd0);
            check("cont_busy", 32'(busy2), (n <= 18) ? 32'd1 : 32'd0);
            if (n == 7 || n == 13 || n == 19) begin
                check("cont_valid", 32'(valid2), 32'd1);
                check("cont_data", 32'(data2), (n == 13) ? 32'd7 : 32'd3);
                $display("cont frame end cycle=%0d data=%b", n, data2);
            end else begin
                check("cont_novalid", 32'(valid2), 32'd0);
            end
            tick();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
